// File: rtl/shift_engine_pkg.sv
// Shared encodings for the shift_engine block: FSM states, fill modes, directions
// and the latched operation descriptor.
package shift_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
  } op_t;

  // Bit entering the vacated end for one single-position shift.
  function automatic logic fill_bit(input logic dir, input logic [1:0] mode,
                                    input logic msb, input logic lsb,
                                    input logic in_sh);
    logic f;
    f = 1'b0;
    case (mode)
      MODE_LOG: f = 1'b0;
      MODE_ARI: f = (dir == DIR_R) ? msb : 1'b0;
      MODE_ROT: f = (dir == DIR_R) ? lsb : msb;
      MODE_SER: f = in_sh;
      default:  f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/shift_engine_step.sv
// shift_step: combinational single-position shift of the register value, producing
// the next value and the bit that falls off the end.
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             in_sh,
  output logic [WIDTH-1:0] nxt,
  output logic             exit_bit
);

  logic fill;

  always_comb begin
    fill = fill_bit(dir, mode, cur[WIDTH-1], cur[0], in_sh);
    if (dir == DIR_L) begin
      nxt      = {cur[WIDTH-2:0], fill};
      exit_bit = cur[WIDTH-1];
    end else begin
      nxt      = {fill, cur[WIDTH-1:1]};
      exit_bit = cur[0];
    end
  end

endmodule

// File: rtl/shift_engine.sv
// shift_engine: multi-cycle shift-by-N unit, one bit position per cycle, with
// busy/done handshake. Optional abort input enabled by SHIFT_ENGINE_ABORT_EN.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
`ifdef SHIFT_ENGINE_ABORT_EN
  input  logic             abort,
`endif
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             in_sh,
  output logic [WIDTH-1:0] out,
  output logic             out_sh,
  output logic             busy,
  output logic             done
);

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_nxt;
  logic             step_exit;
  logic             abort_hit;

`ifdef SHIFT_ENGINE_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .cur      (out),
    .dir      (op.dir),
    .mode     (op.mode),
    .in_sh    (in_sh),
    .nxt      (step_nxt),
    .exit_bit (step_exit)
  );

  // busy/done are flopped alongside the state so every output comes from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op     <= '0;
      cnt    <= '0;
      out    <= '0;
      out_sh <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (load) begin
            out    <= in;
            out_sh <= 1'b0;
          end else if (start) begin
            op  <= '{dir: dir, mode: mode};
            cnt <= amount;
            if (amount != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (abort_hit) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            out    <= step_nxt;
            out_sh <= step_exit;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
